// File: rtl/branch_ctrl.sv
// Control-flow front end: decodes LTH/SETC/BR/HALT against registered branch state
// and sequences the fetch unit through RUN, IDLE and HALT.
module branch_ctrl #(
   parameter int unsigned TW  = 10,
   parameter int unsigned LOW = 5
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [8:0]    Instr,
   input  logic          FlagWe,
   input  logic          ZeroIn,
   input  logic          NegIn,
   output logic          Jump,
   output logic          BranchAbsOrRel,
   output logic [TW-1:0] Target,
   output logic          Done,
   output logic          Armed
);

   localparam int unsigned HW = TW - LOW;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_IDLE = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   tgt_hi_q, tgt_hi_d;
   logic            armed_q, armed_d;
   logic [1:0]      cond_q, cond_d;
   logic            mode_q, mode_d;
   logic            z_q, z_d;
   logic            n_q, n_d;
   logic            done_q, done_d;

   logic            jump_c;
   logic            rel_c;
   logic [TW-1:0]   target_c;
   logic            cond_true_c;
   logic            is_ctl_c;
   logic            is_halt_c;
   logic [LOW-1:0]  lo_c;

   assign lo_c      = Instr[LOW-1:0];
   assign is_ctl_c  = (Instr[8:6] == 3'b110);
   assign is_halt_c = is_ctl_c && (Instr[5:0] == 6'b111111);

   // Condition evaluation uses the registered flags only.
   always_comb begin
      cond_true_c = 1'b1;
      case (cond_q)
         2'b00:   cond_true_c = 1'b1;
         2'b01:   cond_true_c = z_q;
         2'b10:   cond_true_c = ~z_q;
         default: cond_true_c = n_q;
      endcase
   end

   // Next-state and combinational redirect outputs.
   always_comb begin
      state_d  = state_q;
      tgt_hi_d = tgt_hi_q;
      armed_d  = armed_q;
      cond_d   = cond_q;
      mode_d   = mode_q;
      z_d      = z_q;
      n_d      = n_q;
      jump_c   = 1'b0;
      rel_c    = 1'b0;
      target_c = '0;

      case (state_q)
         S_RUN: begin
            if (!Start) begin
               if (is_halt_c) begin
                  state_d = S_HALT;
                  jump_c  = 1'b1;
                  rel_c   = 1'b1;
               end else if (is_ctl_c && !Instr[5]) begin
                  tgt_hi_d = HW'(lo_c);
                  armed_d  = 1'b1;
               end else if (is_ctl_c) begin
                  cond_d = Instr[1:0];
                  mode_d = Instr[2];
               end else if (Instr[8:6] == 3'b111) begin
                  armed_d = 1'b0;
                  if (cond_true_c ^ Instr[5]) begin
                     jump_c   = 1'b1;
                     rel_c    = mode_q;
                     target_c = armed_q ? {tgt_hi_q, lo_c}
                                        : TW'($signed(lo_c));
                  end
               end
            end
         end
         S_IDLE: begin
            if (!Start) state_d = S_RUN;
         end
         S_HALT: begin
            // PC parks on itself: relative jump by zero.
            jump_c = 1'b1;
            rel_c  = 1'b1;
         end
         default: state_d = S_RUN;
      endcase

      if (FlagWe) begin
         z_d = ZeroIn;
         n_d = NegIn;
      end

      if (Start) begin
         state_d = S_IDLE;
         armed_d = 1'b0;
         cond_d  = 2'b00;
         mode_d  = 1'b0;
         z_d     = 1'b0;
         n_d     = 1'b0;
      end

      done_d = (state_d == S_HALT);

      if (Reset) begin
         jump_c   = 1'b0;
         rel_c    = 1'b0;
         target_c = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_RUN;
         tgt_hi_q <= '0;
         armed_q  <= 1'b0;
         cond_q   <= 2'b00;
         mode_q   <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tgt_hi_q <= tgt_hi_d;
         armed_q  <= armed_d;
         cond_q   <= cond_d;
         mode_q   <= mode_d;
         z_q      <= z_d;
         n_q      <= n_d;
         done_q   <= done_d;
      end
   end

   assign Jump           = jump_c;
   assign BranchAbsOrRel = rel_c;
   assign Target         = target_c;
   assign Done           = done_q;
   assign Armed          = armed_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: directed scenarios plus random instruction
// streams checked against a behavioural model of the branch unit.
module tb_branch_ctrl;

   logic       Clk = 1'b0;
   logic       Reset, Start, FlagWe, ZeroIn, NegIn;
   logic [8:0] Instr;
   logic       Jump, BranchAbsOrRel, Done, Armed;
   logic [9:0] Target;

   branch_ctrl #(.TW(10), .LOW(5)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr),
      .FlagWe(FlagWe), .ZeroIn(ZeroIn), .NegIn(NegIn),
      .Jump(Jump), .BranchAbsOrRel(BranchAbsOrRel), .Target(Target),
      .Done(Done), .Armed(Armed)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       jump;
      logic       rel;
      logic [9:0] tgt;
      logic       done;
      logic       armed;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   bit      m_idle, m_halt, m_armed, m_mode, m_z, m_n;
   int      m_hi, m_cond;

   function automatic void model_reset();
      m_idle = 0; m_halt = 0; m_armed = 0; m_mode = 0; m_z = 0; m_n = 0;
      m_hi = 0; m_cond = 0;
   endfunction

   function automatic bit cond_holds();
      case (m_cond)
         0: return 1'b1;
         1: return m_z;
         2: return !m_z;
         default: return m_n;
      endcase
   endfunction

   function automatic exp_t model_out(bit rst, bit st, logic [8:0] ins);
      exp_t e;
      int   lo, off;
      e = '0;
      e.done  = m_halt;
      e.armed = m_armed;
      lo = int'(ins[4:0]);
      if (rst) return e;
      if (m_halt) begin
         e.jump = 1; e.rel = 1; e.tgt = 10'd0;
      end else if (!m_idle && !st) begin
         if (ins[8:6] == 3'b110 && ins[5:0] == 6'b111111) begin
            e.jump = 1; e.rel = 1; e.tgt = 10'd0;
         end else if (ins[8:6] == 3'b111 && (cond_holds() != ins[5])) begin
            e.jump = 1;
            e.rel  = m_mode;
            if (m_armed) e.tgt = 10'(m_hi * 32 + lo);
            else begin
               off   = (lo >= 16) ? lo - 32 : lo;
               e.tgt = 10'((off + 1024) % 1024);
            end
         end
      end
      return e;
   endfunction

   function automatic void model_step(bit rst, bit st, logic [8:0] ins, bit fw, bit zi, bit ni);
      if (rst) begin
         model_reset();
         return;
      end
      if (st) begin
         m_idle = 1; m_halt = 0; m_armed = 0; m_cond = 0; m_mode = 0; m_z = 0; m_n = 0;
         return;
      end
      if (m_idle) m_idle = 0;
      else if (!m_halt) begin
         if (ins[8:6] == 3'b110) begin
            if (ins[5:0] == 6'b111111) m_halt = 1;
            else if (!ins[5]) begin m_hi = int'(ins[4:0]); m_armed = 1; end
            else begin m_cond = int'(ins[1:0]); m_mode = ins[2]; end
         end else if (ins[8:6] == 3'b111) m_armed = 0;
      end
      if (fw) begin m_z = zi; m_n = ni; end
   endfunction

   task automatic step(bit rst, bit st, logic [8:0] ins, bit fw = 0, bit zi = 0, bit ni = 0);
      @(negedge Clk);
      Reset = rst; Start = st; Instr = ins; FlagWe = fw; ZeroIn = zi; NegIn = ni;
      exp_q.push_back(model_out(rst, st, ins));
      @(posedge Clk);
      #1 model_step(rst, st, ins, fw, zi, ni);
   endtask

   task automatic check(string name, logic [9:0] act, logic [9:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: samples DUT outputs mid-low-phase and retires one expectation per cycle.
   always @(negedge Clk) begin
      #2;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("jump",   10'(Jump),           10'(e.jump));
         check("rel",    10'(BranchAbsOrRel), 10'(e.rel));
         check("target", Target,              e.tgt);
         check("done",   10'(Done),           10'(e.done));
         check("armed",  10'(Armed),          10'(e.armed));
      end
   end

   function automatic logic [8:0] rand_instr();
      logic [8:0] r;
      int         k;
      r = 9'($urandom);
      k = $urandom_range(0, 19);
      if (k < 5)       r[8:5] = 4'b1100;
      else if (k < 9)  r[8:5] = 4'b1101;
      else if (k < 16) r[8:6] = 3'b111;
      else if (k == 16) r = 9'b110_111111;
      return r;
   endfunction

   initial begin
      Reset = 1; Start = 0; Instr = '0; FlagWe = 0; ZeroIn = 0; NegIn = 0;
      repeat (2) @(posedge Clk);
      model_reset();

      // 1: unconditional relative-free BR after reset
      step(1, 0, 9'b000_000000);
      step(0, 0, 9'b111_0_00011);
      // 2: LTH then absolute BR -> 679
      step(0, 0, 9'b110_0_10101);
      step(0, 0, 9'b111_0_00111);
      step(0, 0, 9'b000_000000);
      // 3: SETC Z/rel, BR sees old flag then new flag
      step(0, 0, 9'b110_1_00101);
      step(0, 0, 9'b111_0_11110, 1, 1, 0);
      step(0, 0, 9'b111_0_11110);
      // 4: Cond=!Z inverted
      step(0, 0, 9'b110_1_00010);
      step(0, 0, 9'b000_000000, 1, 1, 0);
      step(0, 0, 9'b111_1_00100);
      step(0, 0, 9'b000_000000, 1, 0, 0);
      step(0, 0, 9'b111_1_00100);
      // 5: HALT, park, Start releases
      step(0, 0, 9'b110_111111);
      repeat (3) step(0, 0, 9'($urandom));
      step(0, 1, 9'b000_000000);
      step(0, 0, 9'b111_0_00001);
      step(0, 0, 9'b111_0_00001);
      // 6: Reset clears a pending LTH; BR then sign-extends
      step(0, 0, 9'b110_0_11111);
      step(1, 0, 9'b000_000000);
      step(0, 0, 9'b111_0_10000);

      // Random streams
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0), rand_instr(),
              1'($urandom), 1'($urandom), 1'($urandom));
      end

      repeat (3) @(posedge Clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
